// File: rtl/sort_out_drain.sv
// Output drain for a streaming sorter: buffers one sorted frame of N elements,
// hands them to a ready/valid consumer and flags ordering, overflow and framing errors.
module sort_out_drain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             done_o,
    output logic             order_err_o,
    output logic             overflow_o,
    output logic             frame_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [CW-1:0]    in_cnt, out_cnt;
    logic [WIDTH-1:0] prev;
    logic             accept, start, full, pop, push, drop, late;

    assign full        = (count == (AW+1)'(DEPTH));
    assign out_valid_o = (count != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign start       = data_valid_i && (state_q == IDLE);
    assign accept      = data_valid_i && ((state_q == IDLE) || (state_q == RUN));
    assign late        = data_valid_i && ((state_q == FLUSH) || (state_q == DONE));
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign push        = accept && (!full || pop);
    assign drop        = accept && full && !pop;
    assign out_data_o  = mem[rd_ptr];
    assign out_last_o  = out_valid_o && (in_cnt == CW'(N)) && (count == (AW+1)'(1));
    assign done_o      = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_valid_i) state_d = RUN;
            RUN:     if (accept && (in_cnt == CW'(N - 1))) state_d = FLUSH;
            FLUSH:   if (pop && (count == (AW+1)'(1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            prev        <= '0;
            order_err_o <= 1'b0;
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
            if (accept) prev <= data_i;

            if (start) begin
                in_cnt      <= CW'(1);
                out_cnt     <= '0;
                order_err_o <= 1'b0;
                overflow_o  <= 1'b0;
                frame_err_o <= 1'b0;
            end else begin
                if (accept) in_cnt <= in_cnt + CW'(1);
                if (pop) out_cnt <= out_cnt + CW'(1);
                if (accept && (data_i > prev)) order_err_o <= 1'b1;
                if (drop) overflow_o <= 1'b1;
                if (late) frame_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_out_drain.sv
// Directed bench for sort_out_drain (N=8, DEPTH=4, WIDTH=8).
module tb_sort_out_drain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       out_ready_i = 1'b0;
    logic       out_valid_o, out_last_o, done_o, order_err_o, overflow_o, frame_err_o;
    logic [7:0] out_data_o;

    sort_out_drain #(.WIDTH(8), .N(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_valid_i(data_valid_i), .data_i(data_i),
        .out_ready_i(out_ready_i), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .done_o(done_o), .order_err_o(order_err_o),
        .overflow_o(overflow_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         last_cyc = -100;
    int         done_cyc = -200;
    logic [8:0] got_q[$];
    logic [7:0] stim [9];
    logic [8:0] exp_v [8];

    always @(posedge clk) cyc++;

    // Records {last,data} of every transfer that the coming rising edge performs.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            got_q.push_back({out_last_o, out_data_o});
            if (out_last_o) last_cyc = cyc;
        end
        if (rst_n && done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic set_desc(input int top);
        for (int i = 0; i < 9; i++) stim[i] = 8'(top - 10 * i);
    endtask

    task automatic drive_frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_valid_i = 1'b1;
            data_i = stim[i];
        end
        @(posedge clk); #1;
        data_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (c < 200 && !ok) begin
            @(posedge clk); #1;
            c++;
            if (done_cnt > d0) ok = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid_o, out_last_o, done_o} !== 3'b000)
            $display("FAIL reset_ctrl got %b want 000", {out_valid_o, out_last_o, done_o});
        else n_pass++;
        n_checks++;
        if ({order_err_o, overflow_o, frame_err_o} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {order_err_o, overflow_o, frame_err_o});
        else n_pass++;
        n_checks++;
        if (out_data_o !== 8'd0) $display("FAIL reset_data got %0d want 0", out_data_o);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        set_desc(90);
        out_ready_i = 1'b1;
        got_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                n_checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== 8'd90)
                    $display("FAIL basic_latency got v=%b d=%0d want v=1 d=90", out_valid_o, out_data_o);
                else n_pass++;
            end
            data_valid_i = 1'b1;
            data_i = stim[i];
        end
        @(posedge clk); #1;
        data_valid_i = 1'b0;
        wait_done(d0, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_done_timeout got no done want done");
        else n_pass++;
        n_checks++;
        if (got_q.size() != 8) $display("FAIL basic_count got %0d want 8", got_q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = {(i == 7), stim[i]};
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) $display("FAIL basic_elem%0d got %h want %h", i, got_q[i], exp_v[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (done_cyc - last_cyc != 1) $display("FAIL basic_done_delay got %0d want 1", done_cyc - last_cyc);
        else n_pass++;
        n_checks++;
        if ({order_err_o, overflow_o, frame_err_o} !== 3'b000)
            $display("FAIL basic_flags got %b want 000", {order_err_o, overflow_o, frame_err_o});
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        int d0;
        set_desc(90);
        out_ready_i = 1'b0;
        got_q.delete();
        d0 = done_cnt;
        drive_frame(8);
        n_checks++;
        if (overflow_o !== 1'b1 || out_last_o !== 1'b0)
            $display("FAIL ovf_flag got ovf=%b last=%b want ovf=1 last=0", overflow_o, out_last_o);
        else n_pass++;
        out_ready_i = 1'b1;
        wait_done(d0, ok);
        n_checks++;
        if (!ok) $display("FAIL ovf_done_timeout got no done want done");
        else n_pass++;
        n_checks++;
        if (got_q.size() != 4) $display("FAIL ovf_count got %0d want 4", got_q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = {(i == 3), stim[i]};
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) $display("FAIL ovf_elem%0d got %h want %h", i, got_q[i], exp_v[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (overflow_o !== 1'b1 || done_cnt - d0 != 1)
            $display("FAIL ovf_sticky got ovf=%b done=%0d want ovf=1 done=1", overflow_o, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_order();
        bit ok;
        int d0;
        stim[0] = 8'd50; stim[1] = 8'd60; stim[2] = 8'd40; stim[3] = 8'd30;
        stim[4] = 8'd20; stim[5] = 8'd10; stim[6] = 8'd5;  stim[7] = 8'd0;
        out_ready_i = 1'b1;
        got_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                n_checks++;
                if (order_err_o !== 1'b0 || overflow_o !== 1'b0)
                    $display("FAIL order_start got oe=%b ovf=%b want 0 0", order_err_o, overflow_o);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (order_err_o !== 1'b1) $display("FAIL order_set got %b want 1", order_err_o);
                else n_pass++;
            end
            data_valid_i = 1'b1;
            data_i = stim[i];
        end
        @(posedge clk); #1;
        data_valid_i = 1'b0;
        wait_done(d0, ok);
        n_checks++;
        if (!ok || got_q.size() != 8)
            $display("FAIL order_count got done=%b n=%0d want done=1 n=8", ok, got_q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = {(i == 7), stim[i]};
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) $display("FAIL order_elem%0d got %h want %h", i, got_q[i], exp_v[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (order_err_o !== 1'b1) $display("FAIL order_sticky got %b want 1", order_err_o);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        bit ok;
        int d0;
        set_desc(90);
        out_ready_i = 1'b1;
        got_q.delete();
        d0 = done_cnt;
        drive_frame(9);
        wait_done(d0, ok);
        n_checks++;
        if (!ok || got_q.size() != 8)
            $display("FAIL ferr_count got done=%b n=%0d want done=1 n=8", ok, got_q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = {(i == 7), stim[i]};
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) $display("FAIL ferr_elem%0d got %h want %h", i, got_q[i], exp_v[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if ({order_err_o, overflow_o, frame_err_o} !== 3'b001)
            $display("FAIL ferr_flags got %b want 001", {order_err_o, overflow_o, frame_err_o});
        else n_pass++;
    endtask

    task automatic test_toggle();
        bit         stalled = 1'b0;
        bit         ok = 1'b0;
        logic [7:0] stall_d = '0;
        int         d0;
        set_desc(200);
        out_ready_i = 1'b0;
        got_q.delete();
        d0 = done_cnt;
        for (int c = 0; c < 80 && !ok; c++) begin
            @(posedge clk); #1;
            if (stalled) begin
                n_checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== stall_d)
                    $display("FAIL toggle_stall got v=%b d=%0d want v=1 d=%0d", out_valid_o, out_data_o, stall_d);
                else n_pass++;
            end
            data_valid_i = (c < 16) && (c % 2 == 0);
            data_i = stim[(c / 2) % 8];
            out_ready_i = ~out_ready_i;
            stalled = out_valid_o && !out_ready_i;
            stall_d = out_data_o;
            if (done_cnt > d0) ok = 1'b1;
        end
        data_valid_i = 1'b0;
        out_ready_i = 1'b1;
        n_checks++;
        if (!ok || got_q.size() != 8)
            $display("FAIL toggle_count got done=%b n=%0d want done=1 n=8", ok, got_q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = {(i == 7), stim[i]};
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) $display("FAIL toggle_elem%0d got %h want %h", i, got_q[i], exp_v[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if ({order_err_o, overflow_o, frame_err_o} !== 3'b000)
            $display("FAIL toggle_flags got %b want 000", {order_err_o, overflow_o, frame_err_o});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        out_ready_i = 1'b0;
        stim[0] = 8'd10; stim[1] = 8'd20; stim[2] = 8'd30;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            data_valid_i = 1'b1;
            data_i = stim[i];
        end
        @(posedge clk); #1;
        data_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b1 || order_err_o !== 1'b1)
            $display("FAIL rmid_pre got v=%b oe=%b want v=1 oe=1", out_valid_o, order_err_o);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid_o, out_last_o, done_o, order_err_o, overflow_o, frame_err_o, out_data_o} !== 14'd0)
            $display("FAIL rmid_outputs got %b want 0",
                     {out_valid_o, out_last_o, done_o, order_err_o, overflow_o, frame_err_o, out_data_o});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_desc(90);
        out_ready_i = 1'b1;
        got_q.delete();
        d0 = done_cnt;
        drive_frame(8);
        wait_done(d0, ok);
        n_checks++;
        if (!ok || got_q.size() != 8)
            $display("FAIL rmid_count got done=%b n=%0d want done=1 n=8", ok, got_q.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp_v[i] = {(i == 7), stim[i]};
            if (i < got_q.size()) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) $display("FAIL rmid_elem%0d got %h want %h", i, got_q[i], exp_v[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if ({order_err_o, overflow_o, frame_err_o} !== 3'b000)
            $display("FAIL rmid_flags got %b want 000", {order_err_o, overflow_o, frame_err_o});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_order();
        test_frame_err();
        test_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sort_out_drain.md
SORT_OUT_DRAIN -- requirements
Module: sort_out_drain

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one sorted element.
REQ-002 Parameter N, default 8: number of elements per sorted frame; N >= 2.
REQ-003 Parameter DEPTH, default 4: output buffer depth in elements, power of two, DEPTH >= 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 data_valid_i  input  1  sorter output strobe; one element per cycle while high; no backpressure to the sorter.
REQ-007 data_i  input  WIDTH  sorted element from the sorter, qualified by data_valid_i.
REQ-008 out_ready_i  input  1  consumer ready.
REQ-009 out_valid_o  output  1  out_data_o holds a valid element.
REQ-010 out_data_o  output  WIDTH  element at the buffer head.
REQ-011 out_last_o  output  1  high with out_valid_o on the Nth element of the frame.
REQ-012 done_o  output  1  one-cycle pulse after the last element of the frame is transferred.
REQ-013 order_err_o  output  1  sticky; an element exceeded its predecessor in the current frame.
REQ-014 overflow_o  output  1  sticky; an element was dropped because the buffer was full.
REQ-015 frame_err_o  output  1  sticky; data_valid_i was high after N elements had been captured.

Function
REQ-016 FSM states: IDLE, RUN, FLUSH, DONE.
REQ-017 IDLE: on data_valid_i=1, capture the element, clear all three sticky flags in the same edge, load in_cnt=1, go to RUN.
REQ-018 RUN: each cycle with data_valid_i=1, write data_i and increment in_cnt; when the write makes in_cnt=N, go to FLUSH.
REQ-019 FLUSH: no writes; stay until out_cnt reaches N, then go to DONE.
REQ-020 DONE: done_o=1 for exactly one cycle; next state IDLE.
REQ-021 Transfer occurs on a cycle with out_valid_o=1 and out_ready_i=1; each transfer pops the head and increments out_cnt.
REQ-022 out_valid_o = buffer not empty; out_data_o is the registered head, stable while out_valid_o=1 and out_ready_i=0.
REQ-023 Write-to-output latency: an element written to an empty buffer shows out_valid_o=1 on the next cycle.
REQ-024 Read and write in the same cycle are both performed; occupancy is unchanged.
REQ-025 A write when full with no simultaneous pop is dropped; overflow_o set; in_cnt still increments so the frame ends after N strobes.
REQ-026 With overflow, out_cnt target is the number of elements actually stored; FLUSH exits when the buffer is empty and in_cnt=N.
REQ-027 Frame order is non-increasing: a captured element greater (unsigned) than the previous captured element of the frame sets order_err_o; the element is still stored.
REQ-028 out_last_o=1 when the head is the final stored element of the frame (in_cnt=N and occupancy=1).
REQ-029 data_valid_i=1 in FLUSH or DONE: element ignored, frame_err_o set.
REQ-030 Pointers wrap modulo DEPTH; in_cnt and out_cnt are ceil(log2(N+1)) bits wide.
REQ-031 Sticky flags stay set through DONE and IDLE until the next frame start or reset.

Reset
REQ-032 On rst_n=0, immediately: state IDLE, pointers, occupancy, in_cnt, out_cnt cleared; out_valid_o, out_last_o, done_o, order_err_o, overflow_o, frame_err_o all 0; out_data_o 0.
REQ-033 Reset mid-frame discards all buffered elements; first strobe after release starts a new frame.

Verification
REQ-034 N=8, DEPTH=4, out_ready_i=1, strobe 8 consecutive cycles with 90,80,70,60,50,40,30,20 -> same sequence out, out_last_o with 20, done_o one cycle after 20 transfers, all flags 0.
REQ-035 Same stimulus, out_ready_i=0 until strobes end -> 90,80,70,60 stored, overflow_o=1, then 4 elements out, out_last_o on 60, done_o pulses.
REQ-036 Strobe 50,60,40,... (8 elements), ready=1 -> order_err_o=1 from the cycle after 60 is captured, all 8 elements delivered.
REQ-037 9 consecutive strobes -> 9th ignored, frame_err_o=1, exactly 8 elements delivered.
REQ-038 Toggle out_ready_i every cycle -> out_data_o stable during stall, no loss/duplication, order preserved.
REQ-039 rst_n low after 3 strobes -> all outputs 0 same cycle; new 8-element frame afterwards delivers correctly with flags 0.
